spi_master: RTL and testbench
=============================

# spi_master

SPI bus master for single-byte, full-duplex transfers in SPI mode 0 (CPOL=0, CPHA=0), MSB first. It sits between an internal control FSM or register block and one external SPI slave, and generates SCK, MOSI and an active-low chip select from the system clock. A one-cycle start request launches a transfer. A one-cycle done pulse returns the received byte.

## Interface
- CLK_DIV, default 4: number of clk cycles per SCK half-period; legal range ≥1. SCK frequency = f_clk / (2·CLK_DIV).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) forces the reset state immediately; release is synchronous to clk.
- start_i  in  1  transfer request, sampled on clk; acted on only in IDLE.
- data_i  in  8  byte to transmit; captured on the clk edge that accepts start_i.
- data_o  out  8  last received byte; updated with done_o, held until the next completion.
- done_o  out  1  one-cycle pulse at transfer completion.
- error_o  out  1  one-cycle pulse when start_i is high while a transfer is in progress.
- sck_o  out  1  SPI clock; idles low.
- mosi_o  out  1  serial data to slave.
- miso_i  in  1  serial data from slave; asynchronous to clk, no synchronizer required at SCK ≤ f_clk/2.
- cs_n_o  out  1  active-low slave select; idles high.

## Operation
- All outputs are registered. Reset values: cs_n_o=1, sck_o=0, mosi_o=0, done_o=0, error_o=0, data_o=8'h00, FSM=IDLE, bit counter=0.
- FSM states:
  - IDLE: accepts start_i.
  - SETUP: CS asserted, SCK low.
  - HIGH: SCK high.
  - LOW: SCK low.
  - HOLD: trailing CS time.
  - A half-period counter (0..CLK_DIV-1) advances every state except IDLE.
- IDLE, start_i=1:
  - Load the tx shift register with data_i.
  - Drive cs_n_o=0 and mosi_o=data_i[7].
  - Clear the rx shift register and the bit counter, then go to SETUP.
- SETUP, after CLK_DIV cycles: drive sck_o=1, go to HIGH, and shift miso_i into rx LSB on this same edge.
- HIGH, after CLK_DIV cycles: drive sck_o=0 and increment the bit counter.
  - If 8 bits are done: go to HOLD. mosi_o is left unchanged.
  - Otherwise: drive mosi_o with the next tx bit (MSB first) and go to LOW.
- LOW, after CLK_DIV cycles: drive sck_o=1, shift miso_i into rx, go to HIGH.
- HOLD, after CLK_DIV cycles:
  - Drive cs_n_o=1 and mosi_o=0.
  - Load data_o with the rx register and pulse done_o=1.
  - Go to IDLE.
- Exactly 8 SCK rising edges per transfer. Received byte = {first sampled bit, …, last} (MSB first).
- start_i=1 in any non-IDLE state:
  - error_o pulses one cycle, one pulse per cycle that start_i is high.
  - The request and its data_i are discarded; the ongoing transfer is unaffected.
- start_i in the same cycle that done_o is high is in IDLE's next cycle: a new transfer begins one clk after done_o, with no error.
- rst asserted mid-transfer: abort immediately to reset values; no done_o; data_o clears to 0.

## Timing
- Let D=CLK_DIV and E0 = the clk edge accepting start_i. Edge numbers below count clk edges after E0.
  - cs_n_o falls after E0; mosi_o = bit 7 from the same edge.
  - SCK rising edge k (k=0..7) at E0+D+2Dk, with MISO sampled there.
  - SCK falling edge k at E0+2D+2Dk; MOSI changes there for k<7.
  - cs_n_o rises, done_o=1 and data_o valid after E0+17D.
- Latency, start accept to done pulse: 17·D clk cycles (34 for D=2, 17 for D=1).
- CS setup before first SCK rise = D cycles. CS hold after last SCK fall = D cycles. Minimum CS-high between transfers = 1 cycle.
- done_o and error_o are exactly one cycle wide.

## Test plan
- Reset: hold rst=0 with random inputs → cs_n_o=1, sck_o=0, mosi_o=0, done_o=0, error_o=0, data_o=00.
- CLK_DIV=2, data_i=A5, mode-0 slave returning 5A (shifts on SCK fall, first bit valid at CS fall) → the checks below.
  - 8 SCK pulses, each 2 clk high / 2 low.
  - MOSI at rising edges = 1,0,1,0,0,1,0,1.
  - done_o single pulse 34 cycles after start; data_o=5A; cs_n_o high with done.
- start_i pulsed again at cycle 10 of the previous transfer → error_o one-cycle pulse; MOSI/SCK sequence and data_o=5A unchanged; only one done_o.
- Back-to-back, CLK_DIV=1: data_i=FF then 00, second start one cycle after the first done_o; slave returns 81 then 7E → data_o=81 then 7E; each done 17 cycles after its start; cs_n_o high ≥1 cycle between transfers; no error_o.
- rst asserted after the 4th SCK rise → all outputs at reset values within the same cycle; no done_o; a following A5 transfer completes normally.
- start_i held high 3 cycles from IDLE → one transfer, error_o high for 2 cycles.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), one full-duplex byte per start_i, MSB first.
// Latency: done_o pulses 17*CLK_DIV clk cycles after the edge that accepts start_i.
// Backpressure: none; start_i while a transfer is running is dropped and flagged on error_o.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic       error_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_n_o
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  // tx holds only the bits not yet presented on mosi (bit 7 goes out at accept)
  logic [6:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          half_done;

  assign half_done = (div_cnt_q == DIV_LAST);

  // Next-state logic: every non-idle state lasts one SCK half-period (CLK_DIV cycles)
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    if (state_q == IDLE) begin
      div_cnt_d = '0;
      if (start_i) begin
        tx_d      = data_i[6:0];
        mosi_d    = data_i[7];
        cs_n_d    = 1'b0;
        rx_d      = '0;
        bit_cnt_d = '0;
        state_d   = SETUP;
      end
    end else begin
      // a request while busy is reported and otherwise ignored
      error_d   = start_i;
      div_cnt_d = half_done ? '0 : div_cnt_q + 1'b1;
      if (half_done) begin
        case (state_q)
          SETUP, LOW: begin
            sck_d   = 1'b1;
            rx_d    = {rx_q[6:0], miso_i};
            state_d = HIGH;
          end
          HIGH: begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = HOLD;
            end else begin
              mosi_d  = tx_q[6];
              tx_d    = {tx_q[5:0], 1'b0};
              state_d = LOW;
            end
          end
          HOLD: begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            data_d  = rx_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and output registers; reset aborts any transfer immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign data_o  = data_q;
  assign done_o  = done_q;
  assign error_o = error_q;
  assign sck_o   = sck_q;
  assign mosi_o  = mosi_q;
  assign cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked every cycle
// against a waveform model indexed by cycles since the accepting edge.
// Directed scenarios pin the model with literal values; a random phase follows.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start [2];
  logic [7:0] din   [2];
  logic       miso  [2];
  logic [7:0] dout  [2];
  logic       done  [2];
  logic       err   [2];
  logic       sck   [2];
  logic       mosi  [2];
  logic       csn   [2];

  // model state
  bit         busy     [2];
  int         n        [2];
  bit [7:0]   txd      [2];
  bit [7:0]   rxb      [2];
  bit [7:0]   exp_data [2];
  bit         err_exp  [2];
  bit [7:0]   sb       [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start[0]), .data_i(din[0]), .data_o(dout[0]),
    .done_o(done[0]), .error_o(err[0]), .sck_o(sck[0]), .mosi_o(mosi[0]),
    .miso_i(miso[0]), .cs_n_o(csn[0])
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .data_i(din[1]), .data_o(dout[1]),
    .done_o(done[1]), .error_o(err[1]), .sck_o(sck[1]), .mosi_o(mosi[1]),
    .miso_i(miso[1]), .cs_n_o(csn[1])
  );

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit mdl_idle(input int i);
    return !busy[i] || (n[i] >= 17 * dv(i));
  endfunction

  // Reference model: a transfer is just a cycle count since acceptance plus the bytes involved
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        busy[i]     <= 1'b0;
        n[i]        <= 0;
        err_exp[i]  <= 1'b0;
        exp_data[i] <= 8'h00;
      end else if (busy[i] && n[i] < 17 * dv(i)) begin
        err_exp[i] <= start[i];
        n[i]       <= n[i] + 1;
        if (n[i] + 1 == 17 * dv(i)) exp_data[i] <= rxb[i];
      end else begin
        err_exp[i] <= 1'b0;
        busy[i]    <= start[i];
        n[i]       <= 0;
        if (start[i]) begin
          txd[i] <= din[i];
          rxb[i] <= sb[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of one instance, then drive its slave-side miso for the next edge
  task automatic compare_one(input int i);
    int d, j;
    bit e_cs, e_sck, e_mosi, e_done, e_err;
    bit [7:0] e_data;
    d = dv(i);
    j = n[i] / (2 * d);
    if (j > 7) j = 7;
    e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_done = 1'b0;
    e_err = err_exp[i]; e_data = exp_data[i];
    if (!rst) begin
      e_err = 1'b0; e_data = 8'h00;
    end else if (busy[i] && n[i] < 17 * d) begin
      e_cs   = 1'b0;
      e_sck  = (n[i] >= d) && (n[i] < 16 * d) && (((n[i] - d) / d) % 2 == 0);
      e_mosi = txd[i][7 - j];
    end else begin
      e_done = busy[i] && (n[i] == 17 * d);
    end
    chk("cs_n_o",  i, 32'(csn[i]),  32'(e_cs));
    chk("sck_o",   i, 32'(sck[i]),  32'(e_sck));
    chk("mosi_o",  i, 32'(mosi[i]), 32'(e_mosi));
    chk("done_o",  i, 32'(done[i]), 32'(e_done));
    chk("error_o", i, 32'(err[i]),  32'(e_err));
    chk("data_o",  i, 32'(dout[i]), 32'(e_data));
    if (!rst) miso[i] = 1'($urandom);
    else if (busy[i] && n[i] < 17 * d) miso[i] = rxb[i][7 - j];
    else miso[i] = sb[i][7];
  endtask

  // One clock: compare at the falling edge, return just after the next rising edge
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare_one(i);
    @(posedge clk);
    #2;
  endtask

  task automatic xfer(input int i, input bit [7:0] tx, input bit [7:0] slv, input int hold,
                      input int inj, input int exp_lat, input bit [7:0] exp_rx,
                      input int exp_err, input string tag);
    int d, lat, pulses, errs, bad, hi, lo;
    bit seen, prev;
    bit [7:0] mb;
    d = dv(i); lat = 0; pulses = 0; errs = 0; bad = 0; hi = 0; lo = 0;
    seen = 1'b0; prev = 1'b0; mb = 8'h00;
    sb[i] = slv; din[i] = tx; start[i] = 1'b1;
    cyc();
    while (!seen && lat < 40 * d) begin
      start[i] = (lat + 1 < hold) || (lat == inj);
      din[i]   = start[i] ? 8'($urandom) : tx;
      cyc();
      lat++;
      if (err[i] === 1'b1) errs++;
      if (sck[i] && !prev) begin
        if (pulses > 0 && lo != d) bad++;
        pulses++;
        mb = {mb[6:0], mosi[i]};
        hi = 1;
      end else if (!sck[i] && prev) begin
        if (hi != d) bad++;
        lo = 1;
      end else if (sck[i]) hi++;
      else lo++;
      prev = sck[i];
      if (done[i] === 1'b1) seen = 1'b1;
    end
    start[i] = 1'b0;
    chk({tag, "_latency"},   i, lat, exp_lat);
    chk({tag, "_mosi_bits"}, i, 32'(mb), 32'(tx));
    chk({tag, "_sck_pulses"}, i, pulses, 8);
    chk({tag, "_sck_widths"}, i, bad, 0);
    chk({tag, "_errors"},    i, errs, exp_err);
    chk({tag, "_rx_byte"},   i, 32'(dout[i]), 32'(exp_rx));
    chk({tag, "_cs_n_at_done"}, i, 32'(csn[i]), 32'd1);
  endtask

  initial begin
    int rises, t, dn;
    bit prev;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; din[i] = 8'h00; sb[i] = 8'h00; miso[i] = 1'b0;
    end
    // reset held with random inputs
    repeat (4) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = 1'($urandom);
        din[i]   = 8'($urandom);
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      chk("reset_cs_n",  i, 32'(csn[i]),  32'd1);
      chk("reset_sck",   i, 32'(sck[i]),  32'd0);
      chk("reset_mosi",  i, 32'(mosi[i]), 32'd0);
      chk("reset_done",  i, 32'(done[i]), 32'd0);
      chk("reset_error", i, 32'(err[i]),  32'd0);
      chk("reset_data",  i, 32'(dout[i]), 32'h00);
    end
    rst = 1'b1;
    repeat (2) cyc();

    xfer(0, 8'hA5, 8'h5A, 1, -1, 34, 8'h5A, 0, "basic");
    repeat (3) cyc();
    xfer(0, 8'hA5, 8'h5A, 1, 10, 34, 8'h5A, 1, "inject");
    dn = 0;
    repeat (6) begin cyc(); if (done[0] === 1'b1) dn++; end
    chk("inject_single_done", 0, dn, 0);

    xfer(1, 8'hFF, 8'h81, 1, -1, 17, 8'h81, 0, "b2b_first");
    xfer(1, 8'h00, 8'h7E, 1, -1, 17, 8'h7E, 0, "b2b_second");
    repeat (2) cyc();

    xfer(0, 8'h3C, 8'hC3, 3, -1, 34, 8'hC3, 2, "held_start");
    repeat (2) cyc();

    // reset right after the 4th SCK rise
    sb[0] = 8'h5A; din[0] = 8'hA5; start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    rises = 0; prev = 1'b0; t = 0;
    while (rises < 4 && t < 100) begin
      cyc();
      t++;
      if (sck[0] && !prev) rises++;
      prev = sck[0];
    end
    chk("abort_reached_rise4", 0, rises, 4);
    rst = 1'b0;
    #1;
    chk("abort_cs_n",  0, 32'(csn[0]),  32'd1);
    chk("abort_sck",   0, 32'(sck[0]),  32'd0);
    chk("abort_mosi",  0, 32'(mosi[0]), 32'd0);
    chk("abort_done",  0, 32'(done[0]), 32'd0);
    chk("abort_error", 0, 32'(err[0]),  32'd0);
    chk("abort_data",  0, 32'(dout[0]), 32'h00);
    dn = 0;
    repeat (3) begin cyc(); if (done[0] === 1'b1) dn++; end
    rst = 1'b1;
    repeat (40) begin cyc(); if (done[0] === 1'b1) dn++; end
    chk("abort_no_done", 0, dn, 0);
    xfer(0, 8'hA5, 8'h5A, 1, -1, 34, 8'h5A, 0, "after_abort");

    // random traffic including requests while busy and one mid-run reset
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (mdl_idle(i)) sb[i] = 8'($urandom);
        start[i] = ($urandom_range(0, 9) == 0);
        din[i]   = 8'($urandom);
      end
      if (c == 700) rst = 1'b0;
      if (c == 703) rst = 1'b1;
      cyc();
    end
    for (int i = 0; i < 2; i++) start[i] = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
